riscv_hpc_bank: RTL and testbench

Parametrised hardware performance counter bank for the RISC-V core. It has NUM_CNT programmable counters, each selecting one of EVT_W pipeline event lines, plus a 64-bit cycle counter. A global snapshot gives coherent reads. Overflows are sticky and can raise an interrupt. Software accesses the bank through a simple 32-bit register port.

---
 rtl/riscv_hpc_bank.sv | 123 ++++++++++++
 tb/tb_riscv_hpc_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hpc_bank.sv
// Hardware performance counter bank: NUM_CNT event counters plus a 64-bit cycle
// counter. It provides coherent snapshot reads, sticky overflow flags and an overflow interrupt.
module riscv_hpc_bank #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 48,
  parameter int unsigned EVT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [EVT_W-1:0] evt_i,
  input  logic             reg_we,
  input  logic             reg_re,
  input  logic [7:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rvalid,
  output logic             irq_o
);
  localparam int unsigned      HI_W     = CNT_W - 32;
  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               global_en_q;
  logic [63:0]        cyc_q, cyc_snap_q;
  logic [EVT_W-1:0]   prev_q;
  logic [NUM_CNT-1:0] ovf_q, cfg_edge_q, cfg_en_q, cfg_irq_q;
  logic [4:0]         cfg_sel_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_q     [NUM_CNT];
  logic [CNT_W-1:0]   snap_q    [NUM_CNT];

  logic               wr_ctrl, wr_ovf, do_snap, do_clr;
  logic [NUM_CNT-1:0] wr_cfg, pre_lo, pre_hi, lvl, prv, evt, inc, ovf_set;
  logic [31:0]        rd_data;

  // The increment is gated here by CLR and preset so that the overflow flag only sets on a real wrap.
  always_comb begin
    wr_ctrl = reg_we && (reg_addr == 8'h00);
    wr_ovf  = reg_we && (reg_addr == 8'h01);
    do_snap = wr_ctrl && reg_wdata[1];
    do_clr  = wr_ctrl && reg_wdata[2];
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      wr_cfg[i] = reg_we && (reg_addr == 8'(16 + i));
      pre_lo[i] = reg_we && (reg_addr == 8'(32 + 2 * i));
      pre_hi[i] = reg_we && (reg_addr == 8'(33 + 2 * i));
      lvl[i] = 1'b0;
      prv[i] = 1'b0;
      for (int unsigned e = 0; e < EVT_W; e++) begin
        if (cfg_sel_q[i] == 5'(e)) begin
          lvl[i] = evt_i[e];
          prv[i] = prev_q[e];
        end
      end
      evt[i]     = cfg_edge_q[i] ? (lvl[i] & ~prv[i]) : lvl[i];
      inc[i]     = global_en_q && cfg_en_q[i] && evt[i] && !do_clr && !pre_lo[i] && !pre_hi[i];
      ovf_set[i] = inc[i] && (cnt_q[i] == CNT_ONES);
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      8'h00:   rd_data = {31'b0, global_en_q};
      8'h01:   rd_data = 32'(ovf_q);
      8'h02:   rd_data = cyc_snap_q[31:0];
      8'h03:   rd_data = cyc_snap_q[63:32];
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (reg_addr == 8'(16 + i))
        rd_data = {21'b0, cfg_irq_q[i], cfg_en_q[i], cfg_edge_q[i], 3'b0, cfg_sel_q[i]};
      if (reg_addr == 8'(32 + 2 * i))
        rd_data = snap_q[i][31:0];
      if (reg_addr == 8'(33 + 2 * i))
        rd_data = 32'(snap_q[i][CNT_W-1:32]);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      global_en_q <= 1'b0;
      cyc_q       <= '0;
      cyc_snap_q  <= '0;
      prev_q      <= '0;
      ovf_q       <= '0;
      cfg_edge_q  <= '0;
      cfg_en_q    <= '0;
      cfg_irq_q   <= '0;
      irq_o       <= 1'b0;
      reg_rdata   <= '0;
      reg_rvalid  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cfg_sel_q[i] <= '0;
        cnt_q[i]     <= '0;
        snap_q[i]    <= '0;
      end
    end else begin
      prev_q     <= evt_i;
      reg_rvalid <= reg_re;
      if (reg_re)  reg_rdata   <= rd_data;
      if (wr_ctrl) global_en_q <= reg_wdata[0];
      // A new overflow wins over a same-edge write-1-to-clear.
      ovf_q <= (ovf_q & ~({NUM_CNT{wr_ovf}} & reg_wdata[NUM_CNT-1:0])) | ovf_set;
      irq_o <= |(ovf_q & cfg_irq_q);
      if (do_clr)           cyc_q <= '0;
      else if (global_en_q) cyc_q <= cyc_q + 64'd1;
      if (do_snap) cyc_snap_q <= cyc_q;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (wr_cfg[i]) begin
          cfg_sel_q[i]  <= reg_wdata[4:0];
          cfg_edge_q[i] <= reg_wdata[8];
          cfg_en_q[i]   <= reg_wdata[9];
          cfg_irq_q[i]  <= reg_wdata[10];
        end
        if (do_snap) snap_q[i] <= cnt_q[i];
        if (do_clr)         cnt_q[i]             <= '0;
        else if (pre_lo[i]) cnt_q[i][31:0]       <= reg_wdata;
        else if (pre_hi[i]) cnt_q[i][CNT_W-1:32] <= reg_wdata[HI_W-1:0];
        else if (inc[i])    cnt_q[i]             <= cnt_q[i] + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_riscv_hpc_bank.sv
// Directed bench for riscv_hpc_bank. It keeps a scoreboard of expected read data,
// pushes an entry when a read is issued and pops it when reg_rvalid returns.
module tb_riscv_hpc_bank;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] evt_i;
  logic        reg_we, reg_re;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        irq_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  riscv_hpc_bank #(.NUM_CNT(8), .CNT_W(48), .EVT_W(16)) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .evt_i     (evt_i),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_rvalid(reg_rvalid),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every task is entered just after a falling edge. Each write occupies exactly one rising edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    int unsigned n;
    logic [31:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    reg_re = 1'b1; reg_addr = a;
    @(negedge clk);
    reg_re = 1'b0;
    n = 0;
    while (!reg_rvalid && n < 4) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (!reg_rvalid) begin
      checks++;
      errors++;
      $error("FAIL %s_rvalid observed 0 expected 1", t);
    end else begin
      chk(t, 64'(reg_rdata), 64'(e));
      @(negedge clk);
      chk({t, "_pulse"}, 64'(reg_rvalid), 64'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1; evt_i = '0; reg_we = 1'b0; reg_re = 1'b0; reg_addr = '0; reg_wdata = '0;
    #2;
    chk("rst_rdata", 64'(reg_rdata), 64'd0);
    chk("rst_rvalid", 64'(reg_rvalid), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    rd(8'h00, 32'h0, "rst_ctrl");
    rd(8'h01, 32'h0, "rst_ovf");
    rd(8'h20, 32'h0, "rst_cnt0");
    rd(8'h02, 32'h0, "rst_cyc");

    // Counter 0: level mode on line 3 for 10 cycles.
    wr(8'h10, 32'h203);
    rd(8'h10, 32'h203, "cfg0_rb");
    wr(8'h00, 32'h1);
    evt_i[3] = 1'b1;
    repeat (10) @(negedge clk);
    evt_i[3] = 1'b0;
    wr(8'h00, 32'h3);
    rd(8'h20, 32'd10, "lvl_cnt0_lo");
    rd(8'h21, 32'd0, "lvl_cnt0_hi");

    // Counter 1: edge mode on line 5, waveform 1,1,0,1,0,1 gives three rising edges.
    wr(8'h11, 32'h305);
    evt_i[5] = 1'b1; @(negedge clk);
    evt_i[5] = 1'b1; @(negedge clk);
    evt_i[5] = 1'b0; @(negedge clk);
    evt_i[5] = 1'b1; @(negedge clk);
    evt_i[5] = 1'b0; @(negedge clk);
    evt_i[5] = 1'b1; @(negedge clk);
    evt_i[5] = 1'b0;
    wr(8'h00, 32'h3);
    rd(8'h22, 32'd3, "edge_cnt1");
    rd(8'h20, 32'd10, "cnt0_hold");

    // Counter 2: wrap from 2^48-2 with the interrupt enabled. Upper preset bits are ignored.
    wr(8'h12, 32'h607);
    wr(8'h24, 32'hFFFF_FFFE);
    wr(8'h25, 32'hFFFF_FFFF);
    evt_i[7] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("irq_lag", 64'(irq_o), 64'd0);
    @(negedge clk);
    chk("irq_set", 64'(irq_o), 64'd1);
    evt_i[7] = 1'b0;
    wr(8'h00, 32'h3);
    rd(8'h24, 32'd1, "wrap_cnt2_lo");
    rd(8'h25, 32'd0, "wrap_cnt2_hi");
    rd(8'h01, 32'h4, "wrap_ovf");
    wr(8'h01, 32'h4);
    chk("irq_clr_lag", 64'(irq_o), 64'd1);
    @(negedge clk);
    chk("irq_clr", 64'(irq_o), 64'd0);
    rd(8'h01, 32'h0, "ovf_w1c");

    // Preset beats a same-edge increment, and CLR beats both.
    evt_i[3] = 1'b1;
    wr(8'h20, 32'd100);
    evt_i[3] = 1'b0;
    wr(8'h00, 32'h3);
    rd(8'h20, 32'd100, "preset_vs_inc");
    evt_i[3] = 1'b1;
    wr(8'h00, 32'h5);
    evt_i[3] = 1'b0;
    wr(8'h00, 32'h3);
    rd(8'h20, 32'd0, "clr_vs_inc");
    rd(8'h22, 32'd0, "clr_cnt1");
    rd(8'h10, 32'h203, "clr_keeps_cfg");

    // Cycle counter: CLR, then five enabled cycles before the SNAP edge.
    wr(8'h00, 32'h5);
    repeat (5) @(negedge clk);
    wr(8'h00, 32'h3);
    rd(8'h02, 32'd5, "cyc_lo");
    rd(8'h03, 32'd0, "cyc_hi");

    // Unmapped addresses and counters beyond NUM_CNT.
    wr(8'h18, 32'h203);
    rd(8'h18, 32'h0, "cfg8_unmapped");
    rd(8'h30, 32'h0, "cnt8_unmapped");
    rd(8'h40, 32'h0, "addr40_unmapped");

    // A new overflow on bit 2 coincides with its write-1-to-clear.
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h25, 32'h0000_FFFF);
    evt_i[7] = 1'b1;
    @(negedge clk);
    evt_i[7] = 1'b0;
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h25, 32'h0000_FFFF);
    evt_i[7] = 1'b1;
    wr(8'h01, 32'h4);
    evt_i[7] = 1'b0;
    rd(8'h01, 32'h4, "ovf_set_wins");
    chk("irq_after_race", 64'(irq_o), 64'd1);
    wr(8'h00, 32'h5);
    rd(8'h01, 32'h4, "clr_keeps_ovf");
    rd(8'h00, 32'h1, "ctrl_pulse_bits");

    // Asynchronous reset between clock edges, while a read is in flight.
    evt_i[3] = 1'b1;
    reg_re = 1'b1; reg_addr = 8'h01;
    @(posedge clk);
    #1 reg_re = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_rdata", 64'(reg_rdata), 64'd0);
    chk("arst_rvalid", 64'(reg_rvalid), 64'd0);
    chk("arst_irq", 64'(irq_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    evt_i = '0;
    rd(8'h01, 32'h0, "arst_ovf");
    rd(8'h00, 32'h0, "arst_ctrl");
    rd(8'h10, 32'h0, "arst_cfg0");
    rd(8'h24, 32'h0, "arst_snap2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
